// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC gateway.
//   gw_state_e : per-source gateway state (idle / pending / claimed)
//   ID_W       : width of source and target ID fields
//   SRC_MAX    : largest legal source count (IDs 1..31)
//   TGT_MAX    : largest legal target count
package plic_pkg;

    localparam int ID_W    = 5;
    localparam int SRC_MAX = 31;
    localparam int TGT_MAX = 32;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

endpackage

// File: rtl/plic_gateway_src.sv
// Gateway for a single interrupt source: input synchronizer, request FSM
// and owner register.
//   clk, rst_n      : clock, async active-low reset
//   irq_i           : raw level request, asynchronous to clk
//   claim_hit_i     : valid claim addressed to this source
//   claim_tgt_i     : claiming target, captured as owner
//   complete_hit_i  : valid, in-range completion addressed to this source
//   complete_tgt_i  : completing target
//   complete_en_i   : enable bit of the completing target for this source
//   pending_o       : registered, high while in PENDING
//
// state      | meaning
// GW_IDLE    | no request latched, waiting for synchronized irq
// GW_PENDING | request latched, waiting for a claim
// GW_CLAIMED | claimed by owner, further requests masked until completion
module plic_gateway_src
    import plic_pkg::*;
#(
    parameter int SYNC_N = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            irq_i,
    input  logic            claim_hit_i,
    input  logic [ID_W-1:0] claim_tgt_i,
    input  logic            complete_hit_i,
    input  logic [ID_W-1:0] complete_tgt_i,
    input  logic            complete_en_i,
    output logic            pending_o
);

    logic [SYNC_N-1:0] sync_q;
    logic [SYNC_N-1:0] sync_d;
    logic              irq_sync;
    gw_state_e         state_q;
    gw_state_e         state_d;
    logic [ID_W-1:0]   owner_q;
    logic [ID_W-1:0]   owner_d;

    assign sync_d   = {sync_q[SYNC_N-2:0], irq_i};
    assign irq_sync = sync_q[SYNC_N-1];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            GW_IDLE: begin
                if (irq_sync) state_d = GW_PENDING;
            end
            GW_PENDING: begin
                if (claim_hit_i) begin
                    state_d = GW_CLAIMED;
                    owner_d = claim_tgt_i;
                end
            end
            GW_CLAIMED: begin
                // Only the owning target, with the source enabled, may release it.
                if (complete_hit_i && (complete_tgt_i == owner_q) && complete_en_i)
                    state_d = GW_IDLE;
            end
            default: state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= GW_IDLE;
            owner_q <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: one plic_gateway_src per source plus decode and
// range checks of the claim/complete strobes.
//   clk, rst_n      : clock, async active-low reset
//   irq_src         : level requests for sources 1..SRC_N (async)
//   claim_valid/tgt/src       : claim strobe, claiming target, source ID
//   complete_valid/src/tgt    : completion strobe, source ID, target
//   cfg_int_enable  : per-target source enable bits (bit 0 unused)
//   int_pending     : registered pending bits, bit 0 always 0
module plic_gateway
    import plic_pkg::*;
#(
    parameter int SRC_N  = 1,
    parameter int TGT_N  = 1,
    parameter int SYNC_N = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SRC_N:1]              irq_src,
    input  logic                        claim_valid,
    input  logic [ID_W-1:0]             claim_tgt,
    input  logic [ID_W-1:0]             claim_src,
    input  logic                        complete_valid,
    input  logic [ID_W-1:0]             complete_src,
    input  logic [ID_W-1:0]             complete_tgt,
    input  logic [TGT_N-1:0][SRC_N:0]   cfg_int_enable,
    output logic [SRC_N:0]              int_pending
);

    logic           claim_ok;
    logic           complete_ok;
    logic [SRC_N:0] en_row;
    logic [SRC_N:1] pend;
    logic           unused_en;

    assign claim_ok = claim_valid && (claim_src != '0)
                      && (claim_src <= ID_W'(SRC_N));

    // Target compare is one bit wider so TGT_N = 32 is representable.
    assign complete_ok = complete_valid && (complete_src != '0)
                         && (complete_src <= ID_W'(SRC_N))
                         && ({1'b0, complete_tgt} < (ID_W + 1)'(TGT_N));

    // Row select by loop so an out-of-range target never indexes the array.
    always_comb begin
        en_row = '0;
        for (int t = 0; t < TGT_N; t++) begin
            if (complete_tgt == ID_W'(t)) en_row = cfg_int_enable[t];
        end
    end

    assign unused_en = en_row[0];

    for (genvar i = 1; i <= SRC_N; i++) begin : g_src
        plic_gateway_src #(
            .SYNC_N (SYNC_N)
        ) u_src (
            .clk            (clk),
            .rst_n          (rst_n),
            .irq_i          (irq_src[i]),
            .claim_hit_i    (claim_ok && (claim_src == ID_W'(i))),
            .claim_tgt_i    (claim_tgt),
            .complete_hit_i (complete_ok && (complete_src == ID_W'(i))),
            .complete_tgt_i (complete_tgt),
            .complete_en_i  (en_row[i]),
            .pending_o      (pend[i])
        );
    end

    assign int_pending = {pend, 1'b0};

endmodule
